gpio_n: RTL and testbench
=========================

Name: gpio_n

Overview:
- Parametrised next-generation GPIO bank on the ic0 AXI-style interconnect.
- Pin count is configurable, and each pin has per-pin direction, open-drain and output control.
- New in this generation: configurable input synchroniser, rising/falling edge detection with sticky write-1-to-clear status, a level interrupt output, and readback of all control registers.
- Each instance occupies one 64-byte window at BASE+OFFSET.

Parameters:
- GPIO_BW, 8, number of pins (1..32); register bits above GPIO_BW-1 read 0 and ignore writes.
- BASE, 32'h00000440, bank base address (12-bit decode).
- OFFSET, 32'h00000000, instance offset, multiple of 32'h40.
- SYNC_STAGES, 2, input synchroniser flops per pin (2..4).

Ports:
- clk  input  1  clock.
- rst_n  input  1  asynchronous active-low reset.
- gpio_io  inout  GPIO_BW  pins.
- ic0_c_axi_mst_wr_valid  input  1  write strobe, single cycle.
- ic0_axi_mst_wr_addr  input  32  write address.
- ic0_axi_mst_wr_data  input  32  write data.
- ic0_c_axi_mst_rd_valid  input  1  read strobe, single cycle.
- ic0_axi_mst_rd_addr  input  32  read address.
- ic0_c_axi_slv_rd_ready_0  output  1  read data valid.
- ic0_axi_slv_rd_data_0  output  32  read data; 0 when rd_ready is low.
- irq  output  1  level interrupt.

Behaviour:
- Decode: a hit requires addr[11:6] == (BASE+OFFSET)[11:6]. The register is selected by addr[5:2]. Misses are ignored with no response.
- Register map (offset: write / read):
  - 0x00: DIR clr / DIR
  - 0x04: DIR set / DIR
  - 0x08: TRI clr / TRI
  - 0x0C: TRI set / TRI
  - 0x10: OUT clr / OUT
  - 0x14: OUT set / OUT
  - 0x18: RISE_EN full write / RISE_EN
  - 0x1C: FALL_EN full write / FALL_EN
  - 0x20: read-only / DATA_IN
  - 0x24: STAT write-1-to-clear / STAT
  - 0x28..0x3C: writes ignored / read 0
- Write pipeline:
  - A write strobe at cycle N registers address and data; the update is applied at the end of N+1 and is visible from N+2.
  - Back-to-back writes on consecutive cycles are each applied in order.
- Read pipeline:
  - A read hit at cycle N gives rd_ready=1 for exactly one cycle at N+1, with rd_data holding the register value sampled at N.
  - A read miss leaves rd_ready=0.
  - A read and a write in the same cycle are both serviced; the read returns the pre-write value.
- Pin drive, per bit b:
  - DIR=0: Z.
  - DIR=1, TRI=0: drive OUT.
  - DIR=1, TRI=1 (open-drain): OUT=1 gives Z, OUT=0 gives 0.
- Input path: pin -> SYNC_STAGES flops -> DATA_IN register, so DATA_IN latency is SYNC_STAGES+1 cycles. PREV holds DATA_IN delayed by one cycle.
- Edge detect:
  - rise[b] = DATA_IN[b] & ~PREV[b] & RISE_EN[b].
  - fall[b] = ~DATA_IN[b] & PREV[b] & FALL_EN[b].
  - A detected edge sets STAT[b] at the next clock.
- Simultaneous edge set and W1C clear on the same bit: set wins, so STAT stays 1.
- irq = |STAT, registered; it asserts one cycle after STAT becomes nonzero.
- Arming after reset:
  - A saturating counter counts to SYNC_STAGES+2 cycles after rst_n deasserts.
  - Edge detection is suppressed until the counter saturates, so pins idle-high at reset do not produce spurious rise events.
  - Enable changes after arming take effect with the normal write latency; no retroactive events are generated.
- Reset (asynchronous, rst_n=0):
  - DIR/TRI/OUT/RISE_EN/FALL_EN/STAT/sync/DATA_IN/PREV/arm counter all 0; pins Z; rd_ready 0; rd_data 0; irq 0.
  - In-flight writes and reads are discarded.
- Set/clr writes to the same register on consecutive cycles apply in order.
- Within a single write, set and clr are distinct addresses, so they never collide.

Test Plan:
- Reset, then read offsets 0x00..0x24: rd_ready pulses at N+1 each time and every value is 0. Check that all pins are Z and irq=0.
- Write 0x04=0xFF, 0x14=0x0F, 0x08=0xFF, then 0x10=0x01. Required pins: bits [7:4]=0, bits [3:1]=1, bit 0=0. Then write 0x0C=0xF0 with pins pulled up: bits [7:4] read 0 (open-drain, OUT=0).
- Write 0x18=0x01 and hold pin0 at 0 for 10 cycles, then drive 1. Required: STAT=0x01 at SYNC_STAGES+2 cycles after the pin edge and irq=1 one cycle later. Write 0x24=0x01: STAT=0 and irq=0.
- Hold pin3 high through reset release with RISE_EN[3] written to 1 immediately. Required: no STAT bit set. Then toggle pin3 low->high after arming: STAT[3]=1.
- Issue a W1C of STAT bit 2 in the same cycle a falling edge on pin2 sets it (FALL_EN=0x04). Required: STAT[2] remains 1.
- Assert rst_n low mid-write (write strobe at N, reset at N+1). Required: target register stays 0 and rd_ready does not pulse.

Source files
------------

// File: rtl/gpio_n_if.sv
// Bus bundle between the ic0 interconnect master and the gpio_n register bank.
// Handshake: wr_valid/rd_valid are single-cycle strobes with no backpressure; rd_ready_0 is a one-cycle data-valid pulse.
interface gpio_n_if;
    logic        ic0_c_axi_mst_wr_valid;
    logic [31:0] ic0_axi_mst_wr_addr;
    logic [31:0] ic0_axi_mst_wr_data;
    logic        ic0_c_axi_mst_rd_valid;
    logic [31:0] ic0_axi_mst_rd_addr;
    logic        ic0_c_axi_slv_rd_ready_0;
    logic [31:0] ic0_axi_slv_rd_data_0;

    modport master (
        output ic0_c_axi_mst_wr_valid, ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data,
        output ic0_c_axi_mst_rd_valid, ic0_axi_mst_rd_addr,
        input  ic0_c_axi_slv_rd_ready_0, ic0_axi_slv_rd_data_0
    );

    modport slave (
        input  ic0_c_axi_mst_wr_valid, ic0_axi_mst_wr_addr, ic0_axi_mst_wr_data,
        input  ic0_c_axi_mst_rd_valid, ic0_axi_mst_rd_addr,
        output ic0_c_axi_slv_rd_ready_0, ic0_axi_slv_rd_data_0
    );
endinterface

// File: rtl/gpio_n.sv
// GPIO bank: per-pin direction/open-drain/output control, synchronised inputs,
// armed rise/fall edge detection into sticky W1C status, and a level interrupt.
module gpio_n #(
    parameter int          GPIO_BW     = 8,
    parameter logic [31:0] BASE        = 32'h0000_0440,
    parameter logic [31:0] OFFSET      = 32'h0000_0000,
    parameter int          SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    gpio_n_if.slave           bus,
    inout  wire [GPIO_BW-1:0] gpio_io,
    output logic              irq
);
    localparam logic [31:0] LP_WIN     = BASE + OFFSET;
    localparam int          LP_ARM_MAX = SYNC_STAGES + 2;
    localparam int          LP_ARM_W   = $clog2(LP_ARM_MAX + 1);
    localparam logic [LP_ARM_W-1:0] LP_ARM_SAT = LP_ARM_W'(LP_ARM_MAX);

    localparam logic [3:0] SEL_DIR_CLR  = 4'h0;
    localparam logic [3:0] SEL_DIR_SET  = 4'h1;
    localparam logic [3:0] SEL_TRI_CLR  = 4'h2;
    localparam logic [3:0] SEL_TRI_SET  = 4'h3;
    localparam logic [3:0] SEL_OUT_CLR  = 4'h4;
    localparam logic [3:0] SEL_OUT_SET  = 4'h5;
    localparam logic [3:0] SEL_RISE_EN  = 4'h6;
    localparam logic [3:0] SEL_FALL_EN  = 4'h7;
    localparam logic [3:0] SEL_DATA_IN  = 4'h8;
    localparam logic [3:0] SEL_STAT     = 4'h9;

    logic [GPIO_BW-1:0] r_dir, r_tri, r_out, r_rise_en, r_fall_en, r_stat;
    logic [SYNC_STAGES-1:0][GPIO_BW-1:0] r_sync;
    logic [GPIO_BW-1:0] r_data_in, r_prev;
    logic [LP_ARM_W-1:0] r_arm;
    logic               r_wr_vld;
    logic [3:0]         r_wr_sel;
    logic [GPIO_BW-1:0] r_wr_data;
    logic               r_rd_ready;
    logic [31:0]        r_rd_data;
    logic               r_irq;

    logic               w_wr_hit, w_rd_hit, w_armed;
    logic [GPIO_BW-1:0] w_rd_val, w_edge, w_stat_clr, w_oe, w_drv;
    logic               w_unused_bits;

    assign w_wr_hit = bus.ic0_c_axi_mst_wr_valid && (bus.ic0_axi_mst_wr_addr[11:6] == LP_WIN[11:6]);
    assign w_rd_hit = bus.ic0_c_axi_mst_rd_valid && (bus.ic0_axi_mst_rd_addr[11:6] == LP_WIN[11:6]);
    assign w_unused_bits = ^{bus.ic0_axi_mst_wr_addr, bus.ic0_axi_mst_rd_addr, bus.ic0_axi_mst_wr_data};

    // Open-drain pins only ever pull low; a 1 releases the pin.
    assign w_oe  = r_dir & (~r_tri | ~r_out);
    assign w_drv = r_out & ~r_tri;
    for (genvar b = 0; b < GPIO_BW; b++) begin : g_pin
        assign gpio_io[b] = w_oe[b] ? w_drv[b] : 1'bz;
    end

    assign w_armed    = (r_arm == LP_ARM_SAT);
    assign w_edge     = w_armed ? ((r_data_in & ~r_prev & r_rise_en) | (~r_data_in & r_prev & r_fall_en)) : '0;
    assign w_stat_clr = (r_wr_vld && (r_wr_sel == SEL_STAT)) ? r_wr_data : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_vld  <= 1'b0;
            r_wr_sel  <= '0;
            r_wr_data <= '0;
            r_dir     <= '0;
            r_tri     <= '0;
            r_out     <= '0;
            r_rise_en <= '0;
            r_fall_en <= '0;
            r_stat    <= '0;
            r_irq     <= 1'b0;
        end else begin
            r_wr_vld  <= w_wr_hit;
            r_wr_sel  <= bus.ic0_axi_mst_wr_addr[5:2];
            r_wr_data <= bus.ic0_axi_mst_wr_data[GPIO_BW-1:0];
            if (r_wr_vld) begin
                case (r_wr_sel)
                    SEL_DIR_CLR: r_dir     <= r_dir & ~r_wr_data;
                    SEL_DIR_SET: r_dir     <= r_dir | r_wr_data;
                    SEL_TRI_CLR: r_tri     <= r_tri & ~r_wr_data;
                    SEL_TRI_SET: r_tri     <= r_tri | r_wr_data;
                    SEL_OUT_CLR: r_out     <= r_out & ~r_wr_data;
                    SEL_OUT_SET: r_out     <= r_out | r_wr_data;
                    SEL_RISE_EN: r_rise_en <= r_wr_data;
                    SEL_FALL_EN: r_fall_en <= r_wr_data;
                    default: ;
                endcase
            end
            // New edges are ORed in after the clear so a coincident set wins.
            r_stat <= (r_stat & ~w_stat_clr) | w_edge;
            r_irq  <= |r_stat;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync    <= '0;
            r_data_in <= '0;
            r_prev    <= '0;
            r_arm     <= '0;
        end else begin
            r_sync    <= {r_sync[SYNC_STAGES-2:0], gpio_io};
            r_data_in <= r_sync[SYNC_STAGES-1];
            r_prev    <= r_data_in;
            if (!w_armed) begin
                r_arm <= r_arm + 1'b1;
            end
        end
    end

    always_comb begin
        w_rd_val = '0;
        case (bus.ic0_axi_mst_rd_addr[5:2])
            SEL_DIR_CLR, SEL_DIR_SET: w_rd_val = r_dir;
            SEL_TRI_CLR, SEL_TRI_SET: w_rd_val = r_tri;
            SEL_OUT_CLR, SEL_OUT_SET: w_rd_val = r_out;
            SEL_RISE_EN:              w_rd_val = r_rise_en;
            SEL_FALL_EN:              w_rd_val = r_fall_en;
            SEL_DATA_IN:              w_rd_val = r_data_in;
            SEL_STAT:                 w_rd_val = r_stat;
            default:                  w_rd_val = '0;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_rd_ready <= 1'b0;
            r_rd_data  <= '0;
        end else begin
            r_rd_ready <= w_rd_hit;
            r_rd_data  <= w_rd_hit ? 32'(w_rd_val) : '0;
        end
    end

    assign bus.ic0_c_axi_slv_rd_ready_0 = r_rd_ready;
    assign bus.ic0_axi_slv_rd_data_0    = r_rd_data;
    assign irq                          = r_irq;
endmodule

// File: tb/tb_gpio_n.sv
// Directed bench for gpio_n: bus reads are checked by a scoreboard monitor,
// pin levels and irq are checked inline against hand-computed values.
`timescale 1ns/1ps
module tb_gpio_n;
    localparam int          BW = 8;
    localparam logic [31:0] A  = 32'h0000_0440;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    gpio_n_if bus();
    tri1 [BW-1:0] gpio;
    logic irq;
    logic [BW-1:0] tb_en = '1;
    logic [BW-1:0] tb_val = '0;

    for (genvar b = 0; b < BW; b++) begin : g_pad
        assign gpio[b] = tb_en[b] ? tb_val[b] : 1'bz;
    end

    gpio_n #(.GPIO_BW(BW), .BASE(A), .OFFSET(32'h0), .SYNC_STAGES(2)) dut (
        .clk(clk), .rst_n(rst_n), .bus(bus.slave), .gpio_io(gpio), .irq(irq)
    );

    int n_cmp = 0;
    int n_err = 0;
    int cyc = 0;
    logic [31:0] exp_q[$];
    int          cyc_q[$];

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wr(input logic [5:0] off, input logic [31:0] d);
        bus.ic0_c_axi_mst_wr_valid = 1'b1;
        bus.ic0_axi_mst_wr_addr    = A + {26'h0, off};
        bus.ic0_axi_mst_wr_data    = d;
        tick();
        bus.ic0_c_axi_mst_wr_valid = 1'b0;
    endtask

    task automatic rd(input logic [5:0] off, input logic [31:0] e);
        bus.ic0_c_axi_mst_rd_valid = 1'b1;
        bus.ic0_axi_mst_rd_addr    = A + {26'h0, off};
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 1);
        tick();
        bus.ic0_c_axi_mst_rd_valid = 1'b0;
    endtask

    task automatic rd_miss(input logic [31:0] addr);
        bus.ic0_c_axi_mst_rd_valid = 1'b1;
        bus.ic0_axi_mst_rd_addr    = addr;
        tick();
        bus.ic0_c_axi_mst_rd_valid = 1'b0;
    endtask

    task automatic rdwr(input logic [5:0] roff, input logic [31:0] e, input logic [5:0] woff, input logic [31:0] d);
        bus.ic0_c_axi_mst_rd_valid = 1'b1;
        bus.ic0_axi_mst_rd_addr    = A + {26'h0, roff};
        bus.ic0_c_axi_mst_wr_valid = 1'b1;
        bus.ic0_axi_mst_wr_addr    = A + {26'h0, woff};
        bus.ic0_axi_mst_wr_data    = d;
        exp_q.push_back(e);
        cyc_q.push_back(cyc + 1);
        tick();
        bus.ic0_c_axi_mst_rd_valid = 1'b0;
        bus.ic0_c_axi_mst_wr_valid = 1'b0;
    endtask

    // A pin the DUT leaves floating follows whatever the bench forces onto it.
    task automatic probe_z(input logic [BW-1:0] mask, input string name);
        tb_en  = mask;
        tb_val = '0;
        #1;
        check({name, "_low"}, 32'(gpio & mask), 32'h0);
        tb_en = '0;
        #1;
        check({name, "_pull"}, 32'(gpio & mask), 32'(mask));
    endtask

    // Scoreboard monitor
    initial begin
        logic [31:0] e;
        int          c;
        forever begin
            @(negedge clk);
            if (bus.ic0_c_axi_slv_rd_ready_0) begin
                if (exp_q.size() == 0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_unexpected: got rd_ready=1 data %h expected no response (cycle %0d)",
                             bus.ic0_axi_slv_rd_data_0, cyc);
                end else begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    n_cmp++;
                    if (bus.ic0_axi_slv_rd_data_0 !== e || cyc != c) begin
                        n_err++;
                        $display("FAIL rd_data: got %h at cycle %0d expected %h at cycle %0d",
                                 bus.ic0_axi_slv_rd_data_0, cyc, e, c);
                    end
                end
            end else begin
                if (bus.ic0_axi_slv_rd_data_0 !== 32'h0) begin
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_data_idle: got %h expected 00000000 (cycle %0d)", bus.ic0_axi_slv_rd_data_0, cyc);
                end
                if (cyc_q.size() > 0 && cyc > cyc_q[0]) begin
                    e = exp_q.pop_front();
                    c = cyc_q.pop_front();
                    n_cmp++;
                    n_err++;
                    $display("FAIL rd_missing: got no rd_ready by cycle %0d expected data %h at cycle %0d", cyc, e, c);
                end
            end
        end
    end

    initial begin
        bus.ic0_c_axi_mst_wr_valid = 1'b0;
        bus.ic0_axi_mst_wr_addr    = '0;
        bus.ic0_axi_mst_wr_data    = '0;
        bus.ic0_c_axi_mst_rd_valid = 1'b0;
        bus.ic0_axi_mst_rd_addr    = '0;

        // Reset state
        tick(3);
        check("irq_in_reset", 32'(irq), 32'h0);
        check("rd_ready_in_reset", 32'(bus.ic0_c_axi_slv_rd_ready_0), 32'h0);
        probe_z('1, "pins_reset_z");
        tb_en  = '1;
        tb_val = '0;
        rst_n  = 1'b1;
        tick(6);
        for (int i = 0; i < 10; i++) rd(6'(i * 4), 32'h0);
        rd(6'h28, 32'h0);
        rd(6'h3C, 32'h0);
        rd_miss(32'h0000_0480);
        rd_miss(32'h0000_0400);
        tick(3);
        check("irq_after_reset", 32'(irq), 32'h0);

        // Push-pull and open-drain drive
        tb_en = '0;
        tick(4);
        check("pins_idle_pullup", 32'(gpio), 32'h0000_00FF);
        wr(6'h04, 32'h0000_00FF);
        wr(6'h14, 32'hFFFF_FF0F);
        wr(6'h08, 32'h0000_00FF);
        wr(6'h10, 32'h0000_0001);
        tick(2);
        check("pins_pushpull", 32'(gpio), 32'h0000_000E);
        rd(6'h00, 32'h0000_00FF);
        rd(6'h08, 32'h0000_0000);
        rd(6'h10, 32'h0000_000E);
        rd(6'h20, 32'h0000_000E);
        wr(6'h1C, 32'h0000_00A5);
        rd(6'h1C, 32'h0000_0000);
        rd(6'h1C, 32'h0000_00A5);
        wr(6'h1C, 32'h0000_0000);
        wr(6'h0C, 32'h0000_00F0);
        tick(2);
        check("pins_od_low", 32'(gpio), 32'h0000_000E);
        rd(6'h08, 32'h0000_00F0);
        rdwr(6'h10, 32'h0000_000E, 6'h14, 32'h0000_0010);
        tick(2);
        rd(6'h10, 32'h0000_001E);
        check("pins_od_release", 32'(gpio), 32'h0000_001E);
        wr(6'h10, 32'h0000_0010);
        wr(6'h00, 32'h0000_000F);
        wr(6'h04, 32'h0000_0001);
        rd(6'h00, 32'h0000_00F0);
        rd(6'h00, 32'h0000_00F1);
        wr(6'h00, 32'h0000_00FF);
        tick(2);
        tb_en  = '1;
        tb_val = '0;
        tick(6);
        rd(6'h24, 32'h0);

        // Rising edge on pin0, sticky status, irq, W1C
        wr(6'h18, 32'h0000_0001);
        tick(10);
        tb_val[0] = 1'b1;
        tick(3);
        rd(6'h24, 32'h0);
        check("irq_before_edge", 32'(irq), 32'h0);
        rd(6'h24, 32'h0000_0001);
        check("irq_after_edge", 32'(irq), 32'h1);
        tick(5);
        rd(6'h24, 32'h0000_0001);
        rd(6'h20, 32'h0000_0001);
        wr(6'h24, 32'h0000_0001);
        tick(2);
        check("irq_after_w1c", 32'(irq), 32'h0);
        rd(6'h24, 32'h0);
        tick(2);

        // Pin held high through reset release must not raise a rise event
        tb_val = 8'h08;
        rst_n  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        wr(6'h18, 32'h0000_0008);
        tick(8);
        rd(6'h24, 32'h0);
        check("irq_no_spurious", 32'(irq), 32'h0);
        rd(6'h00, 32'h0);
        rd(6'h18, 32'h0000_0008);
        tb_val[3] = 1'b0;
        tick(5);
        tb_val[3] = 1'b1;
        tick(6);
        rd(6'h24, 32'h0000_0008);
        check("irq_armed_rise", 32'(irq), 32'h1);

        // Falling edge set coinciding with W1C of the same bit
        wr(6'h24, 32'h0000_0008);
        wr(6'h1C, 32'h0000_0004);
        tb_val[2] = 1'b1;
        tick(6);
        rd(6'h24, 32'h0);
        tb_val[2] = 1'b0;
        tick(2);
        wr(6'h24, 32'h0000_0004);
        tick(2);
        rd(6'h24, 32'h0000_0004);
        check("irq_set_wins", 32'(irq), 32'h1);
        wr(6'h24, 32'h0000_0004);
        tick(2);
        rd(6'h24, 32'h0);

        // Reset while a write is in flight
        tick(3);
        bus.ic0_c_axi_mst_wr_valid = 1'b1;
        bus.ic0_axi_mst_wr_addr    = A + 32'h04;
        bus.ic0_axi_mst_wr_data    = 32'h0000_0055;
        tick();
        bus.ic0_c_axi_mst_wr_valid = 1'b0;
        rst_n = 1'b0;
        tick(1);
        check("rd_ready_mid_reset", 32'(bus.ic0_c_axi_slv_rd_ready_0), 32'h0);
        tick(1);
        rst_n = 1'b1;
        tick(6);
        rd(6'h00, 32'h0);
        rd(6'h04, 32'h0);

        tick(4);
        check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
